adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one registered adder instance (f/a/b in, y out, 1-cycle latency) between NREQ requesters.
- Round-robin selection; valid/ready request handshake; operands held stable while the adder computes; tagged result returned on a valid/ready response channel.
- Sits between client datapaths and the single adder in the execution cluster.

Parameters:
- WIDTH, 4, operand/result width; must match the attached adder.
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester-ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid_i  input  NREQ  per-requester request valid.
- req_ready_o  output  NREQ  per-requester accept; one-hot or zero.
- req_f_i  input  2*NREQ  function codes; requester k uses bits [2k+1:2k].
- req_a_i  input  WIDTH*NREQ  operand A; requester k uses slice k.
- req_b_i  input  WIDTH*NREQ  operand B; requester k uses slice k.
- add_f_o  output  2  function code to the adder.
- add_a_o  output  WIDTH  operand A to the adder.
- add_b_o  output  WIDTH  operand B to the adder.
- add_y_i  input  WIDTH  adder registered result.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response accept.
- rsp_id_o  output  IDW  index of the requester that owns the response.
- rsp_y_o  output  WIDTH  result.
- rsp_err_o  output  1  illegal-function flag; see Optional Feature.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, rr pointer=0; operand regs, add_*_o, rsp_* and busy_o all 0; req_ready_o=0. Any in-flight operation is discarded with no response. Release is synchronous to clk.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant g = first k with req_valid_i[k]=1, searching ptr, ptr+1, ... mod NREQ.
  - req_ready_o[g]=1 combinationally in this state only. With no valid, req_ready_o=0.
  - At the accepting edge E: latch f/a/b[g] and the ID g; go to ISSUE.
- ISSUE: add_f_o/add_a_o/add_b_o driven from the latched registers. These hold stable through WAIT and RESP and change only at the next accept. Go to WAIT.
- WAIT: the adder sampled at E+1. At E+2, capture add_y_i into rsp_y_o and go to RESP.
- RESP:
  - rsp_valid_o=1 from after E+2, with rsp_id_o=g.
  - rsp_y_o, rsp_id_o and rsp_err_o hold until rsp_valid_o & rsp_ready_i.
  - On that edge: rsp_valid_o=0, ptr=(g+1) mod NREQ, go to IDLE.
- Latency: accept edge E -> rsp_valid_o visible after E+2.
- Throughput: at most one op per 4 cycles; response backpressure stalls in RESP indefinitely.
- No req_ready_o is asserted outside IDLE. A requester dropping valid before being granted is legal and is simply skipped.
- Simultaneous requests: exactly one grant per accept. A requester cannot be granted twice in a row while another requester is asserting valid.
- Width: results are WIDTH bits; carry-out is dropped by the adder and not reconstructed here.
- Function codes pass through unmodified. 2'b11 is unassigned.
- rst asserted in any state: immediate return to reset values, including mid-RESP.

Optional Feature:
- Macro: ADDER_ARB_ILLEGAL_CHECK_EN.
- Defined:
  - A request with f=2'b11 is still accepted normally.
  - ISSUE and WAIT are skipped: IDLE -> RESP on the accepting edge, so rsp_valid_o is visible after E.
  - Response: rsp_y_o=0, rsp_err_o=1; adder inputs stay unchanged.
- Undefined:
  - f=2'b11 follows the normal path; rsp_y_o is whatever add_y_i holds at E+2.
  - rsp_err_o is tied 0.

Test Plan:
- Reset mid-RESP: req0 f=0 a=3 b=4, rst low while rsp_valid_o=1 -> all outputs 0 immediately; after release no response is issued and state is IDLE.
- Single op: req1 f=0 a=5 b=6 (WIDTH=4), rsp_ready_i=1 -> req_ready_o=4'b0010 for one cycle; rsp_valid_o after E+2 with rsp_id_o=1, rsp_y_o=11.
- Round-robin: all 4 valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0; each op spaced exactly 4 cycles.
- Backpressure and wrap: req2 a=15 b=1 f=0, rsp_ready_i=0 for 5 cycles -> rsp_y_o=0 held stable; add_a_o=15 stable; req_ready_o=0 throughout; completes on ready.
- Illegal f=2'b11 from req3 -> with macro: rsp_err_o=1, rsp_y_o=0, rsp_valid_o after E. Without macro: rsp_err_o=0, response after E+2.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request, adder and response signal bundle for adder_arbiter
interface adder_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [2*NREQ-1:0]     req_f_i;
    logic [WIDTH*NREQ-1:0] req_a_i;
    logic [WIDTH*NREQ-1:0] req_b_i;
    logic [1:0]            add_f_o;
    logic [WIDTH-1:0]      add_a_o;
    logic [WIDTH-1:0]      add_b_o;
    logic [WIDTH-1:0]      add_y_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [IDW-1:0]        rsp_id_o;
    logic [WIDTH-1:0]      rsp_y_o;
    logic                  rsp_err_o;
    logic                  busy_o;

    modport slave (
        input  req_valid_i, req_f_i, req_a_i, req_b_i, add_y_i, rsp_ready_i,
        output req_ready_o, add_f_o, add_a_o, add_b_o,
               rsp_valid_o, rsp_id_o, rsp_y_o, rsp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_f_i, req_a_i, req_b_i, add_y_i, rsp_ready_i,
        input  req_ready_o, add_f_o, add_a_o, add_b_o,
               rsp_valid_o, rsp_id_o, rsp_y_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one registered adder among NREQ requesters
// Optional illegal-function short-cut enabled by ADDER_ARB_ILLEGAL_CHECK_EN.
module adder_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input logic            clk,
    input logic            rst,
    adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [1:0]       f_q, f_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [NREQ-1:0]  ready;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [1:0]       gnt_f;
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
    logic             err_q, err_d;
`endif

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // First valid requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && bus.req_valid_i[wrap_idx(ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(ptr_q, i);
            end
        end
    end

    assign gnt_f = bus.req_f_i[2*int'(gnt_idx) +: 2];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        f_d     = f_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        ready   = '0;
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ready   = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
                    id_d    = gnt_idx;
                    f_d     = gnt_f;
                    a_d     = bus.req_a_i[WIDTH*int'(gnt_idx) +: WIDTH];
                    b_d     = bus.req_b_i[WIDTH*int'(gnt_idx) +: WIDTH];
                    state_d = S_ISSUE;
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
                    err_d   = 1'b0;
                    // Unassigned code bypasses the adder; its inputs keep the last legal op.
                    if (gnt_f == 2'b11) begin
                        f_d     = f_q;
                        a_d     = a_q;
                        b_d     = b_q;
                        y_d     = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                y_d     = bus.add_y_i;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    ptr_d   = wrap_idx(id_q, 1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            f_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            f_q     <= f_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.add_f_o     = f_q;
    assign bus.add_a_o     = a_q;
    assign bus.add_b_o     = b_q;
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_id_o    = id_q;
    assign bus.rsp_y_o     = y_q;
    assign bus.busy_o      = (state_q != S_IDLE);
`ifdef ADDER_ARB_ILLEGAL_CHECK_EN
    assign bus.rsp_err_o   = err_q;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif
endmodule
